ball_wall_probe: RTL
====================

Name: ball_wall_probe

Overview:
- Produces the four wall flags (up/down/left/right) that feed the ball-motion stage.
- On each probe tick it snapshots the ball position (ballColumn, ballRow), computes one probe pixel just beyond the ball edge in each direction, and reads the maze cell memory for each.
- It commits all four flags atomically, so the motion stage never sees a mixed old/new set.

Parameters:
- BALL_RADIUS, 4: ball radius in pixels; each probe sits at radius+1 from the centre.
- CELL_SHIFT, 3: log2 of maze cell size in pixels (8-px cells, 32x32 grid).
- ADDR_W, 10: maze address width; must equal 2*(8-CELL_SHIFT).

Ports:
- clk108MHz  in  1  system clock.
- resetPressed  in  1  synchronous active-high reset.
- probeTick  in  1  single-cycle request to start a sweep (driven from the same max-tick as motion).
- ballColumn  in  8  ball centre x (0..255).
- ballRow  in  8  ball centre y (0..255).
- mazeRe  out  1  maze memory read enable.
- mazeAddr  out  ADDR_W  cell address {row>>CELL_SHIFT, col>>CELL_SHIFT}.
- mazeData  in  1  wall bit; valid the cycle after mazeRe (synchronous ROM, latency 1).
- wallAboveball  out  1  wall at up probe.
- wallBelowball  out  1  wall at down probe.
- wallLeftOfball  out  1  wall at left probe.
- wallRightOfball  out  1  wall at right probe.
- wallValid  out  1  one-cycle pulse when the flags update.
- busy  out  1  sweep in progress.

Behaviour:
- Reset (synchronous, resetPressed=1 at a clock edge):
  - All wall flags, wallValid, busy, mazeRe and the pending flag go to 0.
  - mazeAddr goes to 0 and the FSM goes to IDLE.
  - Reset mid-sweep aborts the sweep; the partially collected bits are discarded.
- FSM states: IDLE, PROBE, DRAIN, COMMIT.
  - IDLE: when probeTick=1, snapshot ballColumn/ballRow, set dir=UP, go to PROBE. busy=1 from the next cycle.
  - PROBE: one direction per cycle, in order UP, DOWN, LEFT, RIGHT. Drive mazeAddr/mazeRe for the current direction. After RIGHT, go to DRAIN.
  - DRAIN: capture the final mazeData, go to COMMIT.
  - COMMIT: register the four bits onto the outputs, pulse wallValid for one cycle, clear busy. Then return to IDLE, or go straight to PROBE with a fresh snapshot if pending=1 (pending is cleared).
- Timing, with the tick sampled in cycle 0:
  - Slots are issued in cycles 1..4.
  - The bits are captured in cycles 2..5.
  - The outputs change and wallValid=1 in cycle 6. Fixed latency is 6 cycles, no stalls.
- Probe coordinates use 9-bit signed arithmetic on the snapshot, with D = BALL_RADIUS+1:
  - UP = (col, row-D)
  - DOWN = (col, row+D)
  - LEFT = (col-D, row)
  - RIGHT = (col+D, row)
- Out-of-range probes (coordinate <0 or >255):
  - mazeRe=0 in that slot and the bit is forced to 1 (the playfield edge is a wall).
  - The slot is still consumed, so timing stays fixed.
- In-range probes: mazeRe=1 and the bit is mazeData from the following cycle.
- mazeAddr is held at its last value when mazeRe=0.
- Simultaneous events:
  - probeTick while busy sets pending (one deep; further ticks are merged).
  - probeTick in the COMMIT cycle also sets pending.
  - Ball position changes during a sweep are ignored; only the snapshot is used.
- The wall flags hold their value between commits; they change only in the cycle wallValid=1.

Decomposition:
- Shared package ball_maze_pkg holds:
  - typedef probe_dir_t enum {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}
  - typedef probe_state_t
  - constants BALL_RADIUS, CELL_SHIFT, MAZE_ADDR_W, START_X=128, START_Y=188
- One combinational sub-module, probe_addr_gen, takes (snapshot col/row, dir) and returns (addr, inRange). The FSM and result registers stay in the top module.

Test Plan:
- Reset check: assert resetPressed for 2 cycles -> all flags 0, wallValid 0, busy 0, mazeRe 0.
- Open maze: ROM all 0, ball at (128,188), single tick -> addrs 720, 784, 751, 752 in cycles 1..4 with mazeRe=1; cycle 6 has wallValid=1 and all flags 0.
- Single wall: ROM[752]=1, ball at (128,188) -> at cycle 6 only wallRightOfball=1; flags hold after further ticks with an unchanged ROM.
- Edge clamp: ball at (3,2) with ROM all 0 -> mazeRe=0 in the UP and LEFT slots; wallAboveball=1, wallLeftOfball=1, the other two flags 0.
- Back-to-back: ticks at cycles 0, 3 and 4 -> two commits only, wallValid at cycles 6 and 12; the second sweep uses the position present at cycle 6.
- Reset mid-sweep: ROM[720]=1, tick at 0, reset at cycle 3 -> no wallValid; flags stay 0; a new tick after reset commits normally with wallAboveball=1 six cycles later.

Source files
------------

// File: rtl/ball_maze_pkg.sv
// Shared types and constants for the ball/maze probing logic.
// Maze is a 32x32 grid of 8-px cells covering a 256x256 playfield.
package ball_maze_pkg;

    localparam int BALL_RADIUS = 4;
    localparam int CELL_SHIFT  = 3;
    localparam int MAZE_ADDR_W = 2 * (8 - CELL_SHIFT);

    localparam logic [7:0] START_X = 8'd128;
    localparam logic [7:0] START_Y = 8'd188;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } probe_dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROBE,
        ST_DRAIN,
        ST_COMMIT
    } probe_state_t;

endpackage

// File: rtl/probe_addr_gen.sv
// Maps a ball snapshot and a probe direction to the maze cell address of the
// pixel just beyond the ball edge, flagging probes that leave the playfield.
module probe_addr_gen
    import ball_maze_pkg::*;
#(
    parameter int BALL_RADIUS = ball_maze_pkg::BALL_RADIUS,
    parameter int CELL_SHIFT  = ball_maze_pkg::CELL_SHIFT,
    parameter int ADDR_W      = 2 * (8 - CELL_SHIFT)
) (
    input  logic [7:0]        snap_col,
    input  logic [7:0]        snap_row,
    input  logic [1:0]        dir,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    localparam logic [8:0] DIST = 9'(BALL_RADIUS + 1);

    logic [8:0] probe_x;
    logic [8:0] probe_y;
    logic       unused_low;

    // With |offset| < 256, bit 8 is set exactly when the coordinate is < 0 or > 255.
    always_comb begin
        probe_x = {1'b0, snap_col};
        probe_y = {1'b0, snap_row};
        case (probe_dir_t'(dir))
            DIR_UP:    probe_y = {1'b0, snap_row} - DIST;
            DIR_DOWN:  probe_y = {1'b0, snap_row} + DIST;
            DIR_LEFT:  probe_x = {1'b0, snap_col} - DIST;
            DIR_RIGHT: probe_x = {1'b0, snap_col} + DIST;
            default:   ;
        endcase
        in_range = ~probe_x[8] & ~probe_y[8];
        addr     = {probe_y[7:CELL_SHIFT], probe_x[7:CELL_SHIFT]};
    end

    assign unused_low = ^{probe_x[CELL_SHIFT-1:0], probe_y[CELL_SHIFT-1:0]};

endmodule

// File: rtl/ball_wall_probe.sv
// Sweeps four probe pixels around the ball through the maze ROM and commits
// the resulting up/down/left/right wall flags atomically.
module ball_wall_probe
    import ball_maze_pkg::*;
#(
    parameter int BALL_RADIUS = ball_maze_pkg::BALL_RADIUS,
    parameter int CELL_SHIFT  = ball_maze_pkg::CELL_SHIFT,
    parameter int ADDR_W      = ball_maze_pkg::MAZE_ADDR_W
) (
    input  logic              clk108MHz,
    input  logic              resetPressed,
    input  logic              probeTick,
    input  logic [7:0]        ballColumn,
    input  logic [7:0]        ballRow,
    output logic              mazeRe,
    output logic [ADDR_W-1:0] mazeAddr,
    input  logic              mazeData,
    output logic              wallAboveball,
    output logic              wallBelowball,
    output logic              wallLeftOfball,
    output logic              wallRightOfball,
    output logic              wallValid,
    output logic              busy
);

    probe_state_t      state_q, state_d;
    probe_dir_t        dir_q, dir_d;
    probe_dir_t        rd_dir_q, rd_dir_d;
    logic [7:0]        col_q, col_d;
    logic [7:0]        row_q, row_d;
    logic              pending_q, pending_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_in_range_q, rd_in_range_d;
    logic [3:0]        bits_q, bits_d;
    logic [3:0]        flags_q, flags_d;
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic [ADDR_W-1:0] probe_addr;
    logic              probe_in_range;
    logic              start_sweep;

    probe_addr_gen #(
        .BALL_RADIUS (BALL_RADIUS),
        .CELL_SHIFT  (CELL_SHIFT),
        .ADDR_W      (ADDR_W)
    ) u_addr_gen (
        .snap_col (col_q),
        .snap_row (row_q),
        .dir      (dir_q),
        .addr     (probe_addr),
        .in_range (probe_in_range)
    );

    always_ff @(posedge clk108MHz) begin
        if (resetPressed) begin
            state_q       <= ST_IDLE;
            dir_q         <= DIR_UP;
            rd_dir_q      <= DIR_UP;
            col_q         <= '0;
            row_q         <= '0;
            pending_q     <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_in_range_q <= 1'b0;
            bits_q        <= '0;
            flags_q       <= '0;
            addr_hold_q   <= '0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            rd_dir_q      <= rd_dir_d;
            col_q         <= col_d;
            row_q         <= row_d;
            pending_q     <= pending_d;
            rd_valid_q    <= rd_valid_d;
            rd_in_range_q <= rd_in_range_d;
            bits_q        <= bits_d;
            flags_q       <= flags_d;
            addr_hold_q   <= addr_hold_d;
        end
    end

    // A tick or a queued request in the commit cycle chains straight into the next sweep.
    assign start_sweep = ((state_q == ST_IDLE) && probeTick) ||
                         ((state_q == ST_COMMIT) && (pending_q || probeTick));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (probeTick) state_d = ST_PROBE;
            ST_PROBE:  if (dir_q == DIR_RIGHT) state_d = ST_DRAIN;
            ST_DRAIN:  state_d = ST_COMMIT;
            ST_COMMIT: state_d = (pending_q || probeTick) ? ST_PROBE : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        dir_d     = dir_q;
        pending_d = pending_q;
        if (start_sweep) begin
            col_d     = ballColumn;
            row_d     = ballRow;
            dir_d     = DIR_UP;
            pending_d = 1'b0;
        end else begin
            if (state_q == ST_PROBE) dir_d = probe_dir_t'(dir_q + 2'd1);
            if (probeTick && (state_q != ST_IDLE)) pending_d = 1'b1;
        end

        // Each slot's ROM bit arrives one cycle after issue; off-field probes read as wall.
        rd_valid_d    = (state_q == ST_PROBE);
        rd_dir_d      = dir_q;
        rd_in_range_d = probe_in_range;
        bits_d        = bits_q;
        if (rd_valid_q) bits_d[rd_dir_q] = rd_in_range_q ? mazeData : 1'b1;

        flags_d = flags_q;
        if (state_q == ST_DRAIN) flags_d = bits_d;

        addr_hold_d = mazeAddr;
    end

    always_comb begin
        mazeRe          = (state_q == ST_PROBE) && probe_in_range;
        mazeAddr        = mazeRe ? probe_addr : addr_hold_q;
        wallValid       = (state_q == ST_COMMIT);
        busy            = (state_q == ST_PROBE) || (state_q == ST_DRAIN);
        wallAboveball   = flags_q[DIR_UP];
        wallBelowball   = flags_q[DIR_DOWN];
        wallLeftOfball  = flags_q[DIR_LEFT];
        wallRightOfball = flags_q[DIR_RIGHT];
    end

endmodule
